// File: rtl/swervolf_io_pkg.sv
// Shared constants and helpers for the swervolf board-input conditioner.
package swervolf_io_pkg;

  localparam int SWERVOLF_DBNC_PRESCALE_DEFAULT = 50000;
  localparam int SWERVOLF_DBNC_TICKS_DEFAULT    = 16;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/swervolf_dbnc_ch.sv
// One input channel: synchroniser chain, tick-qualified debounce counter,
// debounced level and registered rise/fall pulses.
module swervolf_dbnc_ch
  import swervolf_io_pkg::*;
#(
  parameter int   SYNC_STAGES    = 2,
  parameter int   DEBOUNCE_TICKS = SWERVOLF_DBNC_TICKS_DEFAULT,
  parameter logic RESET_VAL      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  input  logic i_tick,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = cnt_w(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s      = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], i_in};

  // Any cycle of agreement restarts qualification, tick or not.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (s == stable_q) begin
      cnt_d = '0;
    end else if (i_tick) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = s;
        cnt_d    = '0;
        rise_d   = s;
        fall_d   = ~s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= {SYNC_STAGES{RESET_VAL}};
      cnt_q    <= '0;
      stable_q <= RESET_VAL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign o_stable = stable_q;
  assign o_rise   = rise_q;
  assign o_fall   = fall_q;

endmodule

// File: rtl/swervolf_input_cond.sv
// N-channel switch/button conditioner: shared debounce prescaler, per-channel
// debouncers; sticky event flags and irq only when SWERVOLF_INPUT_COND_EVT_EN is defined.
module swervolf_input_cond
  import swervolf_io_pkg::*;
#(
  parameter int               WIDTH          = 16,
  parameter int               SYNC_STAGES    = 2,
  parameter int               PRESCALE       = SWERVOLF_DBNC_PRESCALE_DEFAULT,
  parameter int               DEBOUNCE_TICKS = SWERVOLF_DBNC_TICKS_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_stable,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  input  logic [WIDTH-1:0] i_evt_clr,
  input  logic [WIDTH-1:0] i_irq_mask,
  output logic [WIDTH-1:0] o_evt,
  output logic             o_irq
);

  localparam int PW = cnt_w(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  // With PRESCALE=1 the counter sits at 0 and tick is permanently high.
  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    swervolf_dbnc_ch #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .RESET_VAL     (RESET_VAL[i])
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .i_in    (i_in[i]),
      .i_tick  (tick),
      .o_stable(o_stable[i]),
      .o_rise  (o_rise[i]),
      .o_fall  (o_fall[i])
    );
  end

`ifdef SWERVOLF_INPUT_COND_EVT_EN
  logic [WIDTH-1:0] evt_q, evt_d;
  logic             irq_q, irq_d;

  // A new edge beats a simultaneous clear so no event is ever lost.
  assign evt_d = (evt_q & ~i_evt_clr) | o_rise | o_fall;
  assign irq_d = |(evt_d & ~i_irq_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      evt_q <= evt_d;
      irq_q <= irq_d;
    end
  end

  assign o_evt = evt_q;
  assign o_irq = irq_q;
`else
  logic unused_evt_inputs;
  assign unused_evt_inputs = ^{i_evt_clr, i_irq_mask};
  assign o_evt = '0;
  assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_swervolf_input_cond.sv
// Scoreboard bench for swervolf_input_cond: a slow debounce instance and a
// PRESCALE=1/DEBOUNCE_TICKS=1 instance, each with its own expected-pulse queue.
module tb_swervolf_input_cond;

`ifdef SWERVOLF_INPUT_COND_EVT_EN
  localparam bit EVT = 1'b1;
`else
  localparam bit EVT = 1'b0;
`endif

  typedef struct {
    int         lo;
    int         hi;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] stable;
  } exp_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  exp_t       q_main[$];
  exp_t       q_fast[$];

  logic       rst, rst_f;
  logic [3:0] m_in, m_clr, m_mask;
  logic [3:0] m_stable, m_rise, m_fall, m_evt;
  logic       m_irq;
  logic [3:0] f_in;
  logic [3:0] f_stable, f_rise, f_fall, f_evt;
  logic       f_irq;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  swervolf_input_cond #(
    .WIDTH(4), .SYNC_STAGES(2), .PRESCALE(4), .DEBOUNCE_TICKS(3), .RESET_VAL(4'b0000)
  ) u_main (
    .clk(clk), .rst(rst), .i_in(m_in), .o_stable(m_stable), .o_rise(m_rise),
    .o_fall(m_fall), .i_evt_clr(m_clr), .i_irq_mask(m_mask), .o_evt(m_evt), .o_irq(m_irq)
  );

  swervolf_input_cond #(
    .WIDTH(4), .SYNC_STAGES(2), .PRESCALE(1), .DEBOUNCE_TICKS(1), .RESET_VAL(4'b0000)
  ) u_fast (
    .clk(clk), .rst(rst_f), .i_in(f_in), .o_stable(f_stable), .o_rise(f_rise),
    .o_fall(f_fall), .i_evt_clr(4'b0000), .i_irq_mask(4'b0000), .o_evt(f_evt), .o_irq(f_irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic sb_cmp(input string nm, input exp_t e, input logic [3:0] r,
                        input logic [3:0] f, input logic [3:0] s);
    total++;
    if (r !== e.rise || f !== e.fall || s !== e.stable || cyc < e.lo || cyc > e.hi) begin
      bad++;
      $display("FAIL %s: got rise=%b fall=%b stable=%b at cycle %0d, expected rise=%b fall=%b stable=%b in cycles %0d..%0d",
               nm, r, f, s, cyc, e.rise, e.fall, e.stable, e.lo, e.hi);
    end
  endtask

  always @(negedge clk) begin
    if (((|m_rise) === 1'b1) || ((|m_fall) === 1'b1)) begin
      if (q_main.size() == 0) begin
        total++;
        bad++;
        $display("FAIL main_unexpected_pulse: got rise=%b fall=%b at cycle %0d, expected no pulse",
                 m_rise, m_fall, cyc);
      end else begin
        sb_cmp("main_pulse", q_main.pop_front(), m_rise, m_fall, m_stable);
      end
    end
  end

  always @(negedge clk) begin
    if (((|f_rise) === 1'b1) || ((|f_fall) === 1'b1)) begin
      if (q_fast.size() == 0) begin
        total++;
        bad++;
        $display("FAIL fast_unexpected_pulse: got rise=%b fall=%b at cycle %0d, expected no pulse",
                 f_rise, f_fall, cyc);
      end else begin
        sb_cmp("fast_pulse", q_fast.pop_front(), f_rise, f_fall, f_stable);
      end
    end
  end

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic push_main(input int lo, input int hi, input logic [3:0] r,
                           input logic [3:0] f, input logic [3:0] s);
    exp_t e;
    e.lo = lo; e.hi = hi; e.rise = r; e.fall = f; e.stable = s;
    q_main.push_back(e);
  endtask

  task automatic push_fast(input int at, input logic [3:0] r,
                           input logic [3:0] f, input logic [3:0] s);
    exp_t e;
    e.lo = at; e.hi = at; e.rise = r; e.fall = f; e.stable = s;
    q_fast.push_back(e);
  endtask

  task automatic wait_pulse(input int ch, input bit want_rise);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (want_rise ? (m_rise[ch] === 1'b1) : (m_fall[ch] === 1'b1)) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL wait_pulse_ch%0d: got no pulse within 30 cycles, expected %s pulse",
               ch, want_rise ? "rise" : "fall");
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; rst_f = 1'b1;
    m_in = 4'b0000; m_clr = 4'b0000; m_mask = 4'b0000; f_in = 4'b0000;
    repeat (2) cyc1();
    chk("reset_stable", m_stable, 4'b0000);
    chk("reset_edges", {m_rise, m_fall}, 8'h00);
    chk("reset_evt_irq", {m_evt, 3'b000, m_irq}, 8'h00);
    chk("reset_fast_stable", f_stable, 4'b0000);
    rst = 1'b0; rst_f = 1'b0;
    repeat (3) cyc1();

    // Fast instance: level follows input after SYNC_STAGES+1 edges, glitches pass.
    f_in = 4'b0101; n = cyc;
    push_fast(n + 3, 4'b0101, 4'b0000, 4'b0101);
    repeat (6) cyc1();
    chk("fast_level", f_stable, 4'b0101);
    f_in = 4'b0111; n = cyc;
    push_fast(n + 3, 4'b0010, 4'b0000, 4'b0111);
    push_fast(n + 4, 4'b0000, 4'b0010, 4'b0101);
    cyc1();
    f_in = 4'b0101;
    repeat (8) cyc1();
    chk("fast_after_glitch", f_stable, 4'b0101);

    // Clean rising step on channel 0.
    m_in = 4'b0001; n = cyc;
    chk("step_not_early", m_stable, 4'b0000);
    push_main(n + 11, n + 14, 4'b0001, 4'b0000, 4'b0001);
    repeat (20) cyc1();
    chk("step_level", m_stable, 4'b0001);

    // Bounce on channel 1, then hold.
    m_in = 4'b0011; repeat (3) cyc1();
    m_in = 4'b0001; repeat (3) cyc1();
    chk("bounce_no_accept", m_stable, 4'b0001);
    m_in = 4'b0011; n = cyc;
    push_main(n + 11, n + 14, 4'b0010, 4'b0000, 4'b0011);
    repeat (20) cyc1();
    chk("bounce_level", m_stable, 4'b0011);

    // Two channels fall and two rise together.
    m_in = 4'b1100; n = cyc;
    push_main(n + 11, n + 14, 4'b1100, 4'b0011, 4'b1100);
    repeat (20) cyc1();
    chk("multi_level", m_stable, 4'b1100);

    // Reset 8 cycles into a pending change; debounce restarts from the reset edge.
    m_in = 4'b0011;
    repeat (8) cyc1();
    rst = 1'b1; n = cyc;
    cyc1();
    rst = 1'b0;
    chk("midrst_stable", m_stable, 4'b0000);
    chk("midrst_edges", {m_rise, m_fall}, 8'h00);
    push_main(n + 13, n + 13, 4'b0011, 4'b0000, 4'b0011);
    repeat (10) cyc1();
    chk("midrst_not_early", m_stable, 4'b0000);
    repeat (10) cyc1();
    chk("midrst_level", m_stable, 4'b0011);

    // Event flags and interrupt.
    m_clr = 4'b1111; cyc1();
    m_clr = 4'b0000;
    chk("evt_cleared", {m_evt, 3'b000, m_irq}, 8'h00);
    m_in = 4'b0111; n = cyc;
    push_main(n + 11, n + 14, 4'b0100, 4'b0000, 4'b0111);
    wait_pulse(2, 1'b1);
    chk("evt_not_yet", m_evt, 4'b0000);
    @(negedge clk);
    chk("evt_set", m_evt, EVT ? 4'b0100 : 4'b0000);
    chk("irq_unmasked", m_irq, EVT);
    m_mask = 4'b0100;
    @(negedge clk);
    chk("irq_masked", m_irq, 1'b0);
    chk("evt_hold", m_evt, EVT ? 4'b0100 : 4'b0000);
    cyc1();
    m_in = 4'b0011; n = cyc;
    push_main(n + 11, n + 14, 4'b0000, 4'b0100, 4'b0011);
    wait_pulse(2, 1'b0);
    m_clr = 4'b0100;
    @(negedge clk);
    chk("evt_set_wins", m_evt, EVT ? 4'b0100 : 4'b0000);
    @(negedge clk);
    chk("evt_w1c", m_evt, 4'b0000);
    m_clr = 4'b0000; m_mask = 4'b0000;
    @(negedge clk);
    chk("irq_after_clear", m_irq, 1'b0);

    repeat (5) cyc1();
    chk("main_queue_drained", q_main.size(), 0);
    chk("fast_queue_drained", q_fast.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/swervolf_input_cond.md
Name: swervolf_input_cond

Overview:
Parametrised N-channel input conditioner for board switches and buttons on the clk_core domain. It replaces the fixed two-register switch synchroniser with the following per-channel stages:
- a configurable-depth synchroniser;
- a prescaled debounce counter;
- registered rise/fall edge pulses;
- optionally, sticky event flags with a maskable interrupt.

Outputs feed the GPIO input word of swervolf_core, and the UART-select switch.

Parameters:
WIDTH, 16, number of input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
PRESCALE, 50000, clk cycles per debounce tick (>=1; 1 = tick every cycle)
DEBOUNCE_TICKS, 16, consecutive disagreeing ticks needed to accept a new level (>=1)
RESET_VAL, {WIDTH{1'b0}}, reset value of the synchroniser chain and o_stable

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
i_in  in  WIDTH  raw asynchronous pad inputs
o_stable  out  WIDTH  debounced level, registered
o_rise  out  WIDTH  one-cycle pulse, channel accepted 0->1
o_fall  out  WIDTH  one-cycle pulse, channel accepted 1->0
i_evt_clr  in  WIDTH  write-1-to-clear for o_evt
i_irq_mask  in  WIDTH  1 = channel masked from o_irq
o_evt  out  WIDTH  sticky event flags
o_irq  out  1  level interrupt

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - Reset is synchronous and active-high (rst).
  - Every flop updates only on posedge clk.
- Reset values:
  - sync chain and o_stable = RESET_VAL
  - o_rise, o_fall, o_evt, o_irq = 0
  - prescaler and all debounce counters = 0
- Reset mid-operation aborts pending debounce; no edge pulse is emitted in or after the reset cycle.
- Synchroniser: sync[0] <= i_in; sync[k] <= sync[k-1]. Define s = sync[SYNC_STAGES-1].
- Prescaler:
  - Shared counter p, range 0..PRESCALE-1, wraps to 0.
  - tick = (p == PRESCALE-1).
  - Width = $clog2(PRESCALE), minimum 1.
- Per-channel counter c, width $clog2(DEBOUNCE_TICKS+1):
  - s[i] == o_stable[i]: c <= 0 on every cycle, tick or not. Any glitch restarts qualification.
  - s[i] != o_stable[i] and tick and c == DEBOUNCE_TICKS-1: o_stable[i] <= s[i]; c <= 0; o_rise[i] or o_fall[i] <= 1 for exactly one cycle, coincident with the o_stable change.
  - s[i] != o_stable[i] and tick otherwise: c <= c+1.
  - Non-tick cycles with disagreement: c holds.
- o_rise and o_fall are 0 in every other cycle, and are never both 1 on one channel.
- Latency from an i_in step held stable to the o_stable change:
  - minimum SYNC_STAGES + (DEBOUNCE_TICKS-1)*PRESCALE + 1 cycles;
  - maximum SYNC_STAGES + DEBOUNCE_TICKS*PRESCALE cycles.
- Channels are fully independent; several channels may update in the same cycle.
- No overflow: c saturates by construction, because it clears at DEBOUNCE_TICKS-1.

Optional Feature:
Macro: SWERVOLF_INPUT_COND_EVT_EN.
- Defined:
  - Set: o_evt[i] <= 1 when o_rise[i] | o_fall[i] (the cycle after the pulse).
  - Clear: o_evt[i] <= 0 when i_evt_clr[i], otherwise holds.
  - Set and clear in the same cycle: set wins.
  - o_irq registered: o_irq <= |(o_evt_next & ~i_irq_mask), so it is valid in the same cycle as o_evt.
- Not defined:
  - o_evt and o_irq are constant 0.
  - i_evt_clr and i_irq_mask are unused; no flops are inferred.

Decomposition:
- Package swervolf_io_pkg holds:
  - localparams SWERVOLF_DBNC_PRESCALE_DEFAULT=50000 and SWERVOLF_DBNC_TICKS_DEFAULT=16;
  - function cnt_w(n) returning max(1,$clog2(n)).
- Sub-module swervolf_dbnc_ch contains one channel's sync chain, counter, o_stable and edge flops, and takes tick as an input.
- Top-level generates WIDTH instances plus the shared prescaler and the event/irq logic.

Test Plan (WIDTH=4, SYNC_STAGES=2, PRESCALE=4, DEBOUNCE_TICKS=3, RESET_VAL=4'b0000 unless stated):
- Clean step: i_in=4'b0001 held -> o_stable[0]=1 and o_rise=4'b0001 for one cycle, in the window 11..14 cycles after the step; o_fall stays 0.
- Bounce: i_in[1] toggles 1,0,1 every 3 cycles, then holds 1 -> no o_rise[1] until 3 ticks after the final hold; exactly one pulse.
- Falling and multi-channel: from o_stable=4'b0011, set i_in=4'b1100 -> o_rise=4'b1100 and o_fall=4'b0011 in the same cycle.
- Reset mid-debounce: assert rst for 1 cycle 8 cycles after the step -> o_stable=0000, no pulse. After release, the full latency restarts.
- Event (macro on): o_rise[2] pulse -> o_evt[2]=1 next cycle; o_irq=1 with mask 0000 and o_irq=0 with mask 0100. i_evt_clr=0100 coincident with a new pulse -> o_evt[2] stays 1.
- PRESCALE=1, DEBOUNCE_TICKS=1 -> o_stable follows i_in after exactly SYNC_STAGES+1 cycles; 1-cycle glitches do propagate.
